comp_notify_ctrl: RTL and testbench
===================================

Name: comp_notify_ctrl

Overview:
Sequencer between the merged completion queue output (AES/SHA dest addresses) and the system bus. Pops one completion address at a time and issues a single status-word write to that address over a req/ack bus master port. Bounds each attempt with a timeout and retries after a backoff. Raises an interrupt pulse per delivered completion and tracks delivered/dropped counts.

Parameters:
ADDRW, 24, completion/bus address width
DATAW, 8, bus write data width
STATUS_WORD, 8'hA5, value written to dest address on completion
TIMEOUT, 16, max cycles bus_req held per attempt without ack (>=2)
BACKOFF, 4, idle cycles between failed attempt and retry (>=1)
MAX_RETRY, 2, retries after first attempt before drop
CNTW, 8, width of done/drop counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
enable  in  1  permits accepting new completions
comp_addr  in  ADDRW  completion dest address from queue data_out
comp_valid  in  1  queue valid_out
comp_ready  out  1  to queue ready_in; pop strobe = comp_valid & comp_ready
bus_req  out  1  write request, held until ack/err/timeout
bus_addr  out  ADDRW  latched dest address
bus_wdata  out  DATAW  STATUS_WORD while bus_req, else 0
bus_ack  in  1  write accepted (one cycle)
bus_err  in  1  write rejected (one cycle)
irq  out  1  one-cycle pulse per delivered completion
err_flag  out  1  sticky: a completion was dropped
err_clr  in  1  clears err_flag
done_cnt  out  CNTW  delivered count, wraps
drop_cnt  out  CNTW  dropped count, wraps
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; comp_ready=0 while in reset; bus_req=0, bus_addr=0, bus_wdata=0, irq=0, err_flag=0, done_cnt=0, drop_cnt=0, busy=0; retry and timer counters 0. Mid-transaction reset abandons the write and drops the latched address; no irq and no count.
- comp_ready = (state==IDLE) & enable & rst_n, combinational. At most one pop per transaction.
- States: IDLE, REQ, BACKOFF, DONE, FAIL.
- IDLE: on pop at edge N, latch comp_addr into bus_addr, retry=0, timer=0 -> REQ. bus_req is high starting cycle N+1.
- REQ: bus_req=1, bus_wdata=STATUS_WORD; timer increments each REQ cycle.
  - bus_ack -> DONE (ack has priority over err and timeout in the same cycle).
  - else bus_err or timer==TIMEOUT-1: retry==MAX_RETRY -> FAIL; else retry++, -> BACKOFF.
- BACKOFF: bus_req=0 for exactly BACKOFF cycles, then REQ with timer=0; bus_addr held.
- DONE: irq=1 for this single cycle; done_cnt++ (mod 2^CNTW); -> IDLE.
- FAIL: err_flag<=1; drop_cnt++; irq stays 0; -> IDLE.
- Timing: best case is pop at N, req N+1, ack N+1, irq N+2, comp_ready high again N+3. Full timeout failure takes (MAX_RETRY+1)*TIMEOUT + MAX_RETRY*BACKOFF REQ/BACKOFF cycles.
- enable deasserted mid-transaction: current transaction completes normally; only new pops are blocked.
- err_clr clears err_flag; if a FAIL set and err_clr coincide, the set wins.
- bus_ack/bus_err outside REQ are ignored.
- comp_addr is sampled only at the pop edge; later changes have no effect.

Test Plan:
- Reset then idle: enable=1, no valid -> comp_ready=1, bus_req=0, irq never asserted, counters 0.
- Immediate ack: comp_addr=24'hABCDEF popped at edge N; ack at N+1 -> bus_addr=ABCDEF, bus_wdata=A5 at N+1, irq pulse N+2, done_cnt=1, comp_ready high N+3.
- Err then ack: err on first REQ cycle -> bus_req low exactly 4 cycles, retry REQ, ack -> irq, done_cnt=1, drop_cnt=0.
- Persistent timeout: no ack/err, addr 24'h100 -> 3 REQ windows of 16 cycles, 2 backoffs of 4; then err_flag=1, drop_cnt=1, no irq. Next addr 24'h200 is accepted and delivered. err_clr -> err_flag=0.
- Priority: bus_ack and bus_err in the same cycle -> DONE. Ack on timer==15 -> DONE with no retry.
- Backpressure and reset: 5 queued addresses, enable toggled mid-transaction -> in-flight write completes and no new pop occurs until enable=1. Reset asserted while in REQ -> bus_req=0 immediately, counters 0, that addr is not rewritten after release.

Source files
------------

// File: rtl/comp_notify_ctrl.sv
// -----------------------------------------------------------------------------
// comp_notify_ctrl
//
// Sits between the merged AES/SHA completion queue and the system bus. Each
// completion address popped from the queue gets a single status-word write
// issued over a req/ack bus master port. Every write attempt is bounded by a
// timeout; a rejected or timed-out attempt is retried after a fixed idle
// backoff, up to MAX_RETRY retries, after which the completion is dropped.
// Each delivered completion produces a one-cycle irq pulse, and delivered and
// dropped completions are counted.
//
// Ports
//   clk, rst_n           system clock, asynchronous active-low reset
//   enable               permits accepting new completions
//   comp_addr/valid      completion address + valid from the queue
//   comp_ready           ready back to the queue (pop = valid & ready)
//   bus_req/addr/wdata   bus write request, target address, write data
//   bus_ack/bus_err      one-cycle write accepted / rejected responses
//   irq                  one-cycle pulse per delivered completion
//   err_flag/err_clr     sticky "a completion was dropped" flag and its clear
//   done_cnt/drop_cnt    wrapping delivered / dropped counters
//   busy                 controller is not idle
// -----------------------------------------------------------------------------
module comp_notify_ctrl #(
    parameter int                ADDRW       = 24,
    parameter int                DATAW       = 8,
    parameter logic [DATAW-1:0]  STATUS_WORD = 8'hA5,
    parameter int                TIMEOUT     = 16,
    parameter int                BACKOFF     = 4,
    parameter int                MAX_RETRY   = 2,
    parameter int                CNTW        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [ADDRW-1:0] comp_addr,
    input  logic             comp_valid,
    output logic             comp_ready,
    output logic             bus_req,
    output logic [ADDRW-1:0] bus_addr,
    output logic [DATAW-1:0] bus_wdata,
    input  logic             bus_ack,
    input  logic             bus_err,
    output logic             irq,
    output logic             err_flag,
    input  logic             err_clr,
    output logic [CNTW-1:0]  done_cnt,
    output logic [CNTW-1:0]  drop_cnt,
    output logic             busy
);

    // Counter widths are clamped to at least one bit so degenerate parameter
    // values (BACKOFF=1, MAX_RETRY=0) still elaborate cleanly.
    localparam int TW = (TIMEOUT   > 1) ? $clog2(TIMEOUT)     : 1;
    localparam int BW = (BACKOFF   > 1) ? $clog2(BACKOFF)     : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BOFF_LAST  = BW'(BACKOFF - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_BACKOFF = 3'd2,
        S_DONE    = 3'd3,
        S_FAIL    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [ADDRW-1:0] addr_q,  addr_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [BW-1:0]    boff_q,  boff_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             err_flag_q;
    logic [CNTW-1:0]  done_cnt_q;
    logic [CNTW-1:0]  drop_cnt_q;

    logic pop;
    assign pop = comp_valid & comp_ready;

    // ------------------------------------------------------------------
    // State register (also holds the per-transaction datapath registers
    // so a reset abandons the whole transaction in one place).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            timer_q <= '0;
            boff_q  <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            boff_q  <= boff_d;
            retry_q <= retry_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        timer_d = timer_q;
        boff_d  = boff_q;
        retry_d = retry_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    addr_d  = comp_addr;
                    timer_d = '0;
                    retry_d = '0;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                // Ack wins over a simultaneous err or an expiring timer.
                if (bus_ack) begin
                    state_d = S_DONE;
                end else if (bus_err || (timer_q == TIMER_LAST)) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        boff_d  = '0;
                        state_d = S_BACKOFF;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_BACKOFF: begin
                if (boff_q == BOFF_LAST) begin
                    timer_d = '0;
                    state_d = S_REQ;
                end else begin
                    boff_d = boff_q + 1'b1;
                end
            end

            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from the current state)
    // ------------------------------------------------------------------
    always_comb begin
        // rst_n is folded in so the queue never sees ready during reset.
        comp_ready = (state_q == S_IDLE) & enable & rst_n;
        bus_req    = (state_q == S_REQ);
        bus_wdata  = (state_q == S_REQ) ? STATUS_WORD : '0;
        irq        = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
        bus_addr   = addr_q;
        err_flag   = err_flag_q;
        done_cnt   = done_cnt_q;
        drop_cnt   = drop_cnt_q;
    end

    // ------------------------------------------------------------------
    // Completion bookkeeping: counters and sticky drop flag. DONE and FAIL
    // each last exactly one cycle, so they act as single-cycle strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_q <= 1'b0;
            done_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (state_q == S_DONE) begin
                done_cnt_q <= done_cnt_q + 1'b1;
            end
            if (state_q == S_FAIL) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
            // A new drop takes precedence over a coincident clear.
            if (state_q == S_FAIL) begin
                err_flag_q <= 1'b1;
            end else if (err_clr) begin
                err_flag_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_comp_notify_ctrl.sv
// -----------------------------------------------------------------------------
// tb_comp_notify_ctrl
//
// Each transaction is described as a plan: a list of attempts, each ending in
// ack, err, ack+err, or timeout at a chosen REQ cycle. The expected bus
// behaviour (REQ window lengths, backoff gaps, irq vs. drop, counters, sticky
// flag) follows directly from the plan; the bench plays the bus slave from the
// same plan and compares what the controller does.
// -----------------------------------------------------------------------------
module tb_comp_notify_ctrl;

    localparam int ADDRW     = 24;
    localparam int DATAW     = 8;
    localparam int TIMEOUT   = 16;
    localparam int BACKOFF   = 4;
    localparam int MAX_RETRY = 2;
    localparam int CNTW      = 8;
    localparam int STATUS    = 32'hA5;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_TMO  = 3;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [ADDRW-1:0] comp_addr;
    logic             comp_valid;
    logic             comp_ready;
    logic             bus_req;
    logic [ADDRW-1:0] bus_addr;
    logic [DATAW-1:0] bus_wdata;
    logic             bus_ack;
    logic             bus_err;
    logic             irq;
    logic             err_flag;
    logic             err_clr;
    logic [CNTW-1:0]  done_cnt;
    logic [CNTW-1:0]  drop_cnt;
    logic             busy;

    comp_notify_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .comp_addr  (comp_addr),
        .comp_valid (comp_valid),
        .comp_ready (comp_ready),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_err    (bus_err),
        .irq        (irq),
        .err_flag   (err_flag),
        .err_clr    (err_clr),
        .done_cnt   (done_cnt),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int exp_done    = 0;
    int exp_drop    = 0;
    int deliv_total = 0;
    int irq_seen    = 0;
    bit clr_at_fail = 0;

    // Current transaction plan
    int plan_kind [MAX_RETRY+1];
    int plan_k    [MAX_RETRY+1];
    int plan_n    = 0;

    always @(posedge clk) begin
        if (irq === 1'b1) irq_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic plan_clear();
        plan_n = 0;
    endtask

    task automatic plan_add(input int kind, input int k);
        plan_kind[plan_n] = kind;
        plan_k[plan_n]    = k;
        plan_n++;
    endtask

    task automatic plan_random();
        plan_clear();
        for (int a = 0; a <= MAX_RETRY; a++) begin
            plan_add($urandom_range(0, 3), $urandom_range(0, TIMEOUT-1));
            if (plan_kind[a] == K_ACK || plan_kind[a] == K_BOTH) break;
        end
    endtask

    // Called just after a falling edge with the controller idle.
    task automatic run_txn(input logic [ADDRW-1:0] addr, input bit disable_mid);
        int  high;
        int  low;
        int  exp_len;
        bit  delivered;
        enable     = 1'b1;
        comp_addr  = addr;
        comp_valid = 1'b1;
        #1;
        check_eq("pop_ready", 32'(comp_ready), 32'd1);
        @(negedge clk);
        // Address must have been captured at the pop edge only.
        comp_valid = 1'b0;
        comp_addr  = ADDRW'($urandom);
        if (disable_mid) enable = 1'b0;
        delivered = 1'b0;

        for (int a = 0; a < plan_n; a++) begin
            if (a > 0) begin
                low = 0;
                while (!bus_req && low < 64) begin
                    // Responses outside a request window must be ignored.
                    bus_ack = 1'($urandom_range(0, 1));
                    bus_err = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    low++;
                end
                bus_ack = 1'b0;
                bus_err = 1'b0;
                check_eq("backoff_len", 32'(low), 32'(BACKOFF));
            end
            exp_len = (plan_kind[a] == K_TMO) ? TIMEOUT : plan_k[a] + 1;
            high = 0;
            while (bus_req && high < TIMEOUT + 4) begin
                if (high == 0) begin
                    check_eq("bus_addr", 32'(bus_addr), 32'(addr));
                    check_eq("bus_wdata", 32'(bus_wdata), STATUS);
                end
                if (plan_kind[a] != K_TMO && high == plan_k[a]) begin
                    bus_ack = (plan_kind[a] == K_ACK || plan_kind[a] == K_BOTH);
                    bus_err = (plan_kind[a] == K_ERR || plan_kind[a] == K_BOTH);
                end
                @(negedge clk);
                bus_ack = 1'b0;
                bus_err = 1'b0;
                high++;
            end
            check_eq("req_len", 32'(high), 32'(exp_len));
            if (plan_kind[a] == K_ACK || plan_kind[a] == K_BOTH) delivered = 1'b1;
        end

        if (delivered) begin
            check_eq("irq_pulse", 32'(irq), 32'd1);
            exp_done = (exp_done + 1) % (1 << CNTW);
            deliv_total++;
            @(negedge clk);
            check_eq("irq_single", 32'(irq), 32'd0);
        end else begin
            check_eq("irq_on_drop", 32'(irq), 32'd0);
            err_clr  = clr_at_fail;
            exp_drop = (exp_drop + 1) % (1 << CNTW);
            @(negedge clk);
            err_clr = 1'b0;
            check_eq("err_flag_set", 32'(err_flag), 32'd1);
        end
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("ready_after", 32'(comp_ready), 32'(enable));
        check_eq("done_cnt", 32'(done_cnt), 32'(exp_done));
        check_eq("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        check_eq("wdata_idle", 32'(bus_wdata), 32'd0);
        $display("TXN addr=%06h attempts=%0d %s done_cnt=%0d drop_cnt=%0d",
                 addr, plan_n, delivered ? "delivered" : "dropped", done_cnt, drop_cnt);
    endtask

    logic [ADDRW-1:0] bp_addr [5];

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        comp_addr  = '0;
        comp_valid = 1'b0;
        bus_ack    = 1'b0;
        bus_err    = 1'b0;
        err_clr    = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(comp_ready), 32'd0);
        check_eq("rst_req", 32'(bus_req), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("idle_ready", 32'(comp_ready), 32'd1);
            check_eq("idle_req", 32'(bus_req), 32'd0);
            @(negedge clk);
        end
        check_eq("idle_done", 32'(done_cnt), 32'd0);
        check_eq("idle_drop", 32'(drop_cnt), 32'd0);
        check_eq("idle_err", 32'(err_flag), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_addr", 32'(bus_addr), 32'd0);

        // Immediate ack
        plan_clear(); plan_add(K_ACK, 0);
        run_txn(24'hABCDEF, 1'b0);

        // Err on first cycle, then ack
        plan_clear(); plan_add(K_ERR, 0); plan_add(K_ACK, 2);
        run_txn(24'h123456, 1'b0);

        // Persistent timeout -> drop, then next address delivered, then clear
        plan_clear(); plan_add(K_TMO, 0); plan_add(K_TMO, 0); plan_add(K_TMO, 0);
        run_txn(24'h000100, 1'b0);
        plan_clear(); plan_add(K_ACK, 1);
        run_txn(24'h000200, 1'b0);
        check_eq("err_hold", 32'(err_flag), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("err_clr", 32'(err_flag), 32'd0);

        // Priority cases
        plan_clear(); plan_add(K_BOTH, 0);
        run_txn(24'h0A0A0A, 1'b0);
        plan_clear(); plan_add(K_ACK, TIMEOUT-1);
        run_txn(24'h0B0B0B, 1'b0);

        // Drop coinciding with err_clr: the set must win
        clr_at_fail = 1'b1;
        plan_clear(); plan_add(K_ERR, 0); plan_add(K_ERR, 3); plan_add(K_ERR, 1);
        run_txn(24'h0C0C0C, 1'b0);
        clr_at_fail = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("err_clr2", 32'(err_flag), 32'd0);

        // Backpressure with enable dropped mid-transaction
        for (int i = 0; i < 5; i++) bp_addr[i] = 24'h300000 + ADDRW'(i * 24'h11);
        for (int i = 0; i < 5; i++) begin
            plan_clear(); plan_add(K_ACK, i);
            run_txn(bp_addr[i], i == 2);
            if (i == 2) begin
                comp_addr  = bp_addr[3];
                comp_valid = 1'b1;
                for (int c = 0; c < 6; c++) begin
                    #1;
                    check_eq("bp_ready", 32'(comp_ready), 32'd0);
                    check_eq("bp_busy", 32'(busy), 32'd0);
                    @(negedge clk);
                end
                comp_valid = 1'b0;
            end
        end

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            plan_random();
            run_txn(ADDRW'($urandom), 1'b0);
        end

        // Reset in the middle of a request window
        enable     = 1'b1;
        comp_addr  = 24'h0DEAD0;
        comp_valid = 1'b1;
        @(negedge clk);
        comp_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_req", 32'(bus_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req", 32'(bus_req), 32'd0);
        check_eq("mid_rst_ready", 32'(comp_ready), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_done", 32'(done_cnt), 32'd0);
        check_eq("mid_rst_drop", 32'(drop_cnt), 32'd0);
        check_eq("mid_rst_addr", 32'(bus_addr), 32'd0);
        exp_done = 0;
        exp_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("post_rst_req", 32'(bus_req), 32'd0);
        end
        check_eq("post_rst_addr", 32'(bus_addr), 32'd0);

        plan_clear(); plan_add(K_ACK, 0);
        run_txn(24'h0FACE0, 1'b0);

        check_eq("irq_total", 32'(irq_seen), 32'(deliv_total));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
